// File: rtl/cpu_control_unit.sv
// cpu_control_unit
//   Multi-cycle sequencer for the 32-bit, 3-bit-opcode core. Owns pc and ir,
//   walks each instruction through FETCH/DECODE/EXEC/MEM/WB, runs the
//   req/ack handshakes with instruction and data memory, and drives the
//   register-file, ALU and writeback-mux controls.
//
//   Ports
//     clk, rst          single clock, synchronous active-high reset
//     run               level; lets the FSM leave IDLE and keep fetching
//     imem_ack/rdata    instruction memory ack + data (same cycle)
//     dmem_ack          data memory ack, access completes this cycle
//     pc, ir            program counter (= imem address), latched instruction
//     imem_req          fetch request
//     dmem_req/we       data access request / write qualifier
//     rf_we             register-file write enable (dest ir[28:24])
//     alu_op            0 ADD, 1 SUB, 2 AND, 3 OR
//     alu_src_imm       ALU operand B is zero-extended ir[14:0]
//     wb_sel_mem        writeback data from data memory
//     busy              not IDLE and not FAULT
//     instr_done        one-cycle pulse after the retiring edge
//     fault             in FAULT (ack timeout); only rst leaves it
module cpu_control_unit #(
  parameter int unsigned         PC_WIDTH    = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned         ACK_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  input  logic                dmem_ack,
  output logic [PC_WIDTH-1:0] pc,
  output logic [31:0]         ir,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                rf_we,
  output logic [1:0]          alu_op,
  output logic                alu_src_imm,
  output logic                wb_sel_mem,
  output logic                busy,
  output logic                instr_done,
  output logic                fault
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  localparam logic [2:0] OP_LD = 3'd0;
  localparam logic [2:0] OP_ST = 3'd1;

  // Count value that, when another unacked cycle passes, makes the counter
  // reach ACK_TIMEOUT; the FSM enters FAULT on that same edge.
  localparam logic [15:0] WAIT_LAST = 16'(ACK_TIMEOUT - 1);

  logic [2:0]  state;
  logic [15:0] wait_cnt;
  logic [2:0]  opcode;
  logic        retire;

  assign opcode = ir[31:29];

  // A store finishes in MEM; everything else finishes in WB.
  assign retire = (state == S_WB) ||
                  ((state == S_MEM) && dmem_ack && (opcode == OP_ST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      ir         <= '0;
      wait_cnt   <= '0;
      instr_done <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      if (retire) begin
        pc         <= pc + PC_WIDTH'(1);
        instr_done <= 1'b1;
        wait_cnt   <= '0;
        state      <= run ? S_FETCH : S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (run) begin
              state    <= S_FETCH;
              wait_cnt <= '0;
            end
          end
          S_FETCH: begin
            if (imem_ack) begin
              ir    <= imem_rdata;
              state <= S_DECODE;
            end else begin
              wait_cnt <= wait_cnt + 16'd1;
              if (wait_cnt == WAIT_LAST) state <= S_FAULT;
            end
          end
          S_DECODE: begin
            if (opcode == OP_LD || opcode == OP_ST) begin
              state    <= S_MEM;
              wait_cnt <= '0;
            end else begin
              state <= S_EXEC;
            end
          end
          S_EXEC: state <= S_WB;
          S_MEM: begin
            // Store acks are handled by the retire path above.
            if (dmem_ack) begin
              state <= S_WB;
            end else begin
              wait_cnt <= wait_cnt + 16'd1;
              if (wait_cnt == WAIT_LAST) state <= S_FAULT;
            end
          end
          S_FAULT: state <= S_FAULT;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Moore outputs.
  assign imem_req    = (state == S_FETCH);
  assign dmem_req    = (state == S_MEM);
  assign dmem_we     = dmem_req && (opcode == OP_ST);
  assign rf_we       = (state == S_WB);
  // The mux select only matters while writing back; holding it low elsewhere
  // keeps the reset/idle output set quiet even though ir=0 decodes as LD.
  assign wb_sel_mem  = rf_we && (opcode == OP_LD);
  assign alu_src_imm = (opcode == 3'd2) || (opcode == 3'd3);
  assign busy        = (state != S_IDLE) && (state != S_FAULT);
  assign fault       = (state == S_FAULT);

  always_comb begin
    alu_op = 2'd0;
    case (opcode)
      3'd3, 3'd5: alu_op = 2'd1;
      3'd6:       alu_op = 2'd2;
      3'd7:       alu_op = 2'd3;
      default:    alu_op = 2'd0;
    endcase
  end

endmodule
